// File: rtl/pipe_de_stage_if.sv
// Decode->execute bus: ID-side d* fields in, EX-side e* fields out.
// The ID side (or a bench) uses master; the pipeline register uses slave.
interface pipe_de_stage_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ALUC_W = 4,
    parameter int unsigned RN_W   = 5
);
    logic              dvalid;
    logic              dwreg;
    logic              dm2reg;
    logic              dwmem;
    logic              djal;
    logic              daluimm;
    logic              dshift;
    logic [ALUC_W-1:0] daluc;
    logic [DATA_W-1:0] dpc4;
    logic [DATA_W-1:0] da;
    logic [DATA_W-1:0] db;
    logic [DATA_W-1:0] dimm;
    logic [RN_W-1:0]   drn;

    logic              evalid;
    logic              ewreg;
    logic              em2reg;
    logic              ewmem;
    logic              ejal;
    logic              ealuimm;
    logic              eshift;
    logic [ALUC_W-1:0] ealuc;
    logic [DATA_W-1:0] epc4;
    logic [DATA_W-1:0] ea;
    logic [DATA_W-1:0] eb;
    logic [DATA_W-1:0] eimm;
    logic [RN_W-1:0]   ern0;

    modport master (
        output dvalid, dwreg, dm2reg, dwmem, djal, daluimm, dshift,
               daluc, dpc4, da, db, dimm, drn,
        input  evalid, ewreg, em2reg, ewmem, ejal, ealuimm, eshift,
               ealuc, epc4, ea, eb, eimm, ern0
    );

    modport slave (
        input  dvalid, dwreg, dm2reg, dwmem, djal, daluimm, dshift,
               daluc, dpc4, da, db, dimm, drn,
        output evalid, ewreg, em2reg, ewmem, ejal, ealuimm, eshift,
               ealuc, epc4, ea, eb, eimm, ern0
    );
endinterface

// File: rtl/pipe_de_stage.sv
// Decode->execute pipeline register with valid bit, stall/flush control and
// saturating stall/bubble performance counters.
module pipe_de_stage #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ALUC_W = 4,
    parameter int unsigned RN_W   = 5,
    parameter int unsigned CNT_W  = 16
) (
    input  logic             clock,
    input  logic             resetn,
    pipe_de_stage_if.slave   bus,
    input  logic             stall,
    input  logic             flush,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] bubble_cnt
);
    typedef enum logic [1:0] {
        ACT_LOAD  = 2'd0,
        ACT_STALL = 2'd1,
        ACT_FLUSH = 2'd2
    } act_e;

    act_e act;
    logic stall_inc;
    logic bubble_inc;

    logic              valid_q;
    logic              wreg_q;
    logic              m2reg_q;
    logic              wmem_q;
    logic              jal_q;
    logic              aluimm_q;
    logic              shift_q;
    logic [ALUC_W-1:0] aluc_q;
    logic [DATA_W-1:0] pc4_q;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [DATA_W-1:0] imm_q;
    logic [RN_W-1:0]   rn_q;
    logic [CNT_W-1:0]  stall_q;
    logic [CNT_W-1:0]  bubble_q;

    // Flush beats stall beats load; a load of an invalid slot is also a bubble.
    always_comb begin
        act = ACT_LOAD;
        if (flush) begin
            act = ACT_FLUSH;
        end else if (stall) begin
            act = ACT_STALL;
        end
        stall_inc  = (act == ACT_STALL);
        bubble_inc = (act == ACT_FLUSH) || ((act == ACT_LOAD) && !bus.dvalid);
    end

    // Side-effecting controls are gated by valid so evalid=0 never leaks a write.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            valid_q <= 1'b0;
            wreg_q  <= 1'b0;
            m2reg_q <= 1'b0;
            wmem_q  <= 1'b0;
            jal_q   <= 1'b0;
        end else begin
            case (act)
                ACT_FLUSH: begin
                    valid_q <= 1'b0;
                    wreg_q  <= 1'b0;
                    m2reg_q <= 1'b0;
                    wmem_q  <= 1'b0;
                    jal_q   <= 1'b0;
                end
                ACT_LOAD: begin
                    valid_q <= bus.dvalid;
                    wreg_q  <= bus.dwreg  & bus.dvalid;
                    m2reg_q <= bus.dm2reg & bus.dvalid;
                    wmem_q  <= bus.dwmem  & bus.dvalid;
                    jal_q   <= bus.djal   & bus.dvalid;
                end
                default: ;
            endcase
        end
    end

    // Datapath fields only move on a load; flush leaves them as don't-care history.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            aluimm_q <= 1'b0;
            shift_q  <= 1'b0;
            aluc_q   <= '0;
            pc4_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            imm_q    <= '0;
            rn_q     <= '0;
        end else if (act == ACT_LOAD) begin
            aluimm_q <= bus.daluimm;
            shift_q  <= bus.dshift;
            aluc_q   <= bus.daluc;
            pc4_q    <= bus.dpc4;
            a_q      <= bus.da;
            b_q      <= bus.db;
            imm_q    <= bus.dimm;
            rn_q     <= bus.drn;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            stall_q <= '0;
        end else if (cnt_clr) begin
            stall_q <= '0;
        end else if (stall_inc && (stall_q != '1)) begin
            stall_q <= stall_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            bubble_q <= '0;
        end else if (cnt_clr) begin
            bubble_q <= '0;
        end else if (bubble_inc && (bubble_q != '1)) begin
            bubble_q <= bubble_q + 1'b1;
        end
    end

    assign bus.evalid  = valid_q;
    assign bus.ewreg   = wreg_q;
    assign bus.em2reg  = m2reg_q;
    assign bus.ewmem   = wmem_q;
    assign bus.ejal    = jal_q;
    assign bus.ealuimm = aluimm_q;
    assign bus.eshift  = shift_q;
    assign bus.ealuc   = aluc_q;
    assign bus.epc4    = pc4_q;
    assign bus.ea      = a_q;
    assign bus.eb      = b_q;
    assign bus.eimm    = imm_q;
    assign bus.ern0    = rn_q;
    assign stall_cnt   = stall_q;
    assign bubble_cnt  = bubble_q;
endmodule

// File: tb/tb_pipe_de_stage.sv
// Scoreboard bench for pipe_de_stage: expected E-stage state is predicted per
// edge, queued, and compared after the edge; counters use a 4-bit width.
module tb_pipe_de_stage;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned ALUC_W = 4;
    localparam int unsigned RN_W   = 5;
    localparam int unsigned CNT_W  = 4;

    typedef struct packed {
        logic              valid, wreg, m2reg, wmem, jal, aluimm, shift;
        logic [ALUC_W-1:0] aluc;
        logic [DATA_W-1:0] pc4, a, b, imm;
        logic [RN_W-1:0]   rn;
    } din_t;

    typedef struct packed {
        logic              valid, wreg, m2reg, wmem, jal, aluimm, shift;
        logic [ALUC_W-1:0] aluc;
        logic [DATA_W-1:0] pc4, a, b, imm;
        logic [RN_W-1:0]   rn;
        logic [CNT_W-1:0]  scnt, bcnt;
    } st_t;

    logic             clock = 1'b0;
    logic             resetn = 1'b0;
    logic             stall = 1'b0;
    logic             flush = 1'b0;
    logic             cnt_clr = 1'b0;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] bubble_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    st_t model;
    st_t sb[$];
    st_t got;
    st_t exp_s;

    pipe_de_stage_if #(.DATA_W(DATA_W), .ALUC_W(ALUC_W), .RN_W(RN_W)) bus ();

    pipe_de_stage #(
        .DATA_W(DATA_W),
        .ALUC_W(ALUC_W),
        .RN_W  (RN_W),
        .CNT_W (CNT_W)
    ) dut (
        .clock     (clock),
        .resetn    (resetn),
        .bus       (bus.slave),
        .stall     (stall),
        .flush     (flush),
        .cnt_clr   (cnt_clr),
        .stall_cnt (stall_cnt),
        .bubble_cnt(bubble_cnt)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got=timeout required=finish");
        $fatal(1, "watchdog");
    end

    function automatic st_t observe();
        st_t s;
        s.valid  = bus.evalid;
        s.wreg   = bus.ewreg;
        s.m2reg  = bus.em2reg;
        s.wmem   = bus.ewmem;
        s.jal    = bus.ejal;
        s.aluimm = bus.ealuimm;
        s.shift  = bus.eshift;
        s.aluc   = bus.ealuc;
        s.pc4    = bus.epc4;
        s.a      = bus.ea;
        s.b      = bus.eb;
        s.imm    = bus.eimm;
        s.rn     = bus.ern0;
        s.scnt   = stall_cnt;
        s.bcnt   = bubble_cnt;
        return s;
    endfunction

    function automatic din_t rand_din();
        din_t d;
        d = {$urandom, $urandom, $urandom, $urandom, $urandom};
        return d;
    endfunction

    function automatic st_t predict(st_t m, din_t d, logic st, logic fl, logic clr);
        st_t n;
        logic sinc, binc;
        n = m;
        sinc = st && !fl;
        binc = fl || (!st && !d.valid);
        if (fl) begin
            n.valid = 1'b0; n.wreg = 1'b0; n.m2reg = 1'b0; n.wmem = 1'b0; n.jal = 1'b0;
        end else if (!st) begin
            n.valid  = d.valid;
            n.wreg   = d.wreg  && d.valid;
            n.m2reg  = d.m2reg && d.valid;
            n.wmem   = d.wmem  && d.valid;
            n.jal    = d.jal   && d.valid;
            n.aluimm = d.aluimm;
            n.shift  = d.shift;
            n.aluc   = d.aluc;
            n.pc4    = d.pc4;
            n.a      = d.a;
            n.b      = d.b;
            n.imm    = d.imm;
            n.rn     = d.rn;
        end
        if (clr) begin
            n.scnt = '0;
            n.bcnt = '0;
        end else begin
            if (sinc && m.scnt != {CNT_W{1'b1}}) n.scnt = m.scnt + 1'b1;
            if (binc && m.bcnt != {CNT_W{1'b1}}) n.bcnt = m.bcnt + 1'b1;
        end
        return n;
    endfunction

    task automatic apply_din(input din_t d);
        bus.dvalid  = d.valid;
        bus.dwreg   = d.wreg;
        bus.dm2reg  = d.m2reg;
        bus.dwmem   = d.wmem;
        bus.djal    = d.jal;
        bus.daluimm = d.aluimm;
        bus.dshift  = d.shift;
        bus.daluc   = d.aluc;
        bus.dpc4    = d.pc4;
        bus.da      = d.a;
        bus.db      = d.b;
        bus.dimm    = d.imm;
        bus.drn     = d.rn;
    endtask

    // Drive one edge's inputs, queue the predicted state, sample 1 time unit after the edge.
    task automatic drive_cycle(input din_t d, input logic st, input logic fl, input logic clr);
        apply_din(d);
        stall   = st;
        flush   = fl;
        cnt_clr = clr;
        model = predict(model, d, st, fl, clr);
        sb.push_back(model);
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        apply_din('0);
        stall = 1'b0; flush = 1'b0; cnt_clr = 1'b0;
        resetn = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        got = observe();
        n_checks++;
        if (got !== st_t'('0)) begin
            n_fail++;
            $display("FAIL reset_state: got=%h required=0", got);
        end
        model = '0;
        sb.delete();
        @(negedge clock);
        resetn = 1'b1;
    endtask

    task automatic test_load();
        din_t d;
        d = rand_din();
        d.valid = 1'b1; d.wreg = 1'b1; d.a = 32'h1234; d.rn = 5'd7;
        drive_cycle(d, 1'b0, 1'b0, 1'b0);
        exp_s = sb.pop_front();
        got = observe();
        n_checks++;
        if (got !== exp_s) begin
            n_fail++;
            $display("FAIL load_sb: got=%h required=%h", got, exp_s);
        end
        n_checks++;
        if (got.valid !== 1'b1 || got.wreg !== 1'b1 || got.a !== 32'h1234 ||
            got.rn !== 5'd7 || got.scnt !== 4'd0 || got.bcnt !== 4'd0) begin
            n_fail++;
            $display("FAIL load_fields: got v=%b w=%b a=%h rn=%0d s=%0d b=%0d required v=1 w=1 a=1234 rn=7 s=0 b=0",
                     got.valid, got.wreg, got.a, got.rn, got.scnt, got.bcnt);
        end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 3; i++) begin
            drive_cycle(rand_din(), 1'b1, 1'b0, 1'b0);
            exp_s = sb.pop_front();
            got = observe();
            n_checks++;
            if (got !== exp_s) begin
                n_fail++;
                $display("FAIL stall_sb[%0d]: got=%h required=%h", i, got, exp_s);
            end
        end
        n_checks++;
        if (got.scnt !== 4'd3 || got.a !== 32'h1234 || got.rn !== 5'd7) begin
            n_fail++;
            $display("FAIL stall_frozen: got s=%0d a=%h rn=%0d required s=3 a=1234 rn=7",
                     got.scnt, got.a, got.rn);
        end
    endtask

    task automatic test_flush_over_stall();
        din_t d;
        logic [CNT_W-1:0] s0, b0;
        d = rand_din();
        d.valid = 1'b1; d.wmem = 1'b1; d.a = 32'd5;
        drive_cycle(d, 1'b0, 1'b0, 1'b0);
        exp_s = sb.pop_front();
        got = observe();
        n_checks++;
        if (got !== exp_s) begin
            n_fail++;
            $display("FAIL flush_setup: got=%h required=%h", got, exp_s);
        end
        s0 = got.scnt;
        b0 = got.bcnt;
        drive_cycle(rand_din(), 1'b1, 1'b1, 1'b0);
        exp_s = sb.pop_front();
        got = observe();
        n_checks++;
        if (got !== exp_s) begin
            n_fail++;
            $display("FAIL flush_sb: got=%h required=%h", got, exp_s);
        end
        n_checks++;
        if (got.valid !== 1'b0 || got.wmem !== 1'b0 || got.a !== 32'd5 ||
            got.bcnt !== b0 + 1'b1 || got.scnt !== s0) begin
            n_fail++;
            $display("FAIL flush_fields: got v=%b wm=%b a=%h b=%0d s=%0d required v=0 wm=0 a=5 b=%0d s=%0d",
                     got.valid, got.wmem, got.a, got.bcnt, got.scnt, b0 + 1'b1, s0);
        end
    endtask

    task automatic test_invalid_load();
        din_t d;
        logic [CNT_W-1:0] b0;
        b0 = model.bcnt;
        d = rand_din();
        d.valid = 1'b0; d.wreg = 1'b1; d.wmem = 1'b1;
        drive_cycle(d, 1'b0, 1'b0, 1'b0);
        exp_s = sb.pop_front();
        got = observe();
        n_checks++;
        if (got !== exp_s) begin
            n_fail++;
            $display("FAIL invalid_sb: got=%h required=%h", got, exp_s);
        end
        n_checks++;
        if (got.valid !== 1'b0 || got.wreg !== 1'b0 || got.wmem !== 1'b0 || got.bcnt !== b0 + 1'b1) begin
            n_fail++;
            $display("FAIL invalid_fields: got v=%b w=%b wm=%b b=%0d required v=0 w=0 wm=0 b=%0d",
                     got.valid, got.wreg, got.wmem, got.bcnt, b0 + 1'b1);
        end
    endtask

    task automatic test_saturation();
        din_t d;
        d = rand_din();
        d.valid = 1'b1;
        drive_cycle(d, 1'b0, 1'b0, 1'b1);
        void'(sb.pop_front());
        for (int i = 0; i < 20; i++) begin
            drive_cycle(rand_din(), 1'b1, 1'b0, 1'b0);
            exp_s = sb.pop_front();
            got = observe();
            n_checks++;
            if (got !== exp_s) begin
                n_fail++;
                $display("FAIL sat_stall_sb[%0d]: got=%h required=%h", i, got, exp_s);
            end
        end
        n_checks++;
        if (got.scnt !== 4'd15 || got.bcnt !== 4'd0) begin
            n_fail++;
            $display("FAIL sat_stall_cnt: got s=%0d b=%0d required s=15 b=0", got.scnt, got.bcnt);
        end
        drive_cycle(rand_din(), 1'b1, 1'b0, 1'b1);
        exp_s = sb.pop_front();
        got = observe();
        n_checks++;
        if (got.scnt !== 4'd0 || got !== exp_s) begin
            n_fail++;
            $display("FAIL clr_over_stall: got s=%0d (%h) required s=0 (%h)", got.scnt, got, exp_s);
        end
        for (int i = 0; i < 20; i++) begin
            drive_cycle(rand_din(), 1'b0, 1'b1, 1'b0);
            void'(sb.pop_front());
        end
        got = observe();
        n_checks++;
        if (got.bcnt !== 4'd15 || got.scnt !== 4'd0) begin
            n_fail++;
            $display("FAIL sat_bubble_cnt: got b=%0d s=%0d required b=15 s=0", got.bcnt, got.scnt);
        end
        d = rand_din();
        d.valid = 1'b1;
        drive_cycle(d, 1'b0, 1'b0, 1'b1);
        exp_s = sb.pop_front();
        got = observe();
        n_checks++;
        if (got !== exp_s || got.bcnt !== 4'd0 || got.a !== d.a || got.valid !== 1'b1) begin
            n_fail++;
            $display("FAIL clr_with_load: got=%h required=%h", got, exp_s);
        end
    endtask

    task automatic test_back_to_back();
        logic st, fl, clr;
        for (int i = 0; i < 60; i++) begin
            st  = ($urandom_range(0, 3) == 0);
            fl  = ($urandom_range(0, 4) == 0);
            clr = ($urandom_range(0, 15) == 0);
            drive_cycle(rand_din(), st, fl, clr);
            exp_s = sb.pop_front();
            got = observe();
            n_checks++;
            if (got !== exp_s) begin
                n_fail++;
                $display("FAIL b2b_sb[%0d]: got=%h required=%h", i, got, exp_s);
            end
            n_checks++;
            if (!got.valid && (got.wreg || got.m2reg || got.wmem || got.jal)) begin
                n_fail++;
                $display("FAIL b2b_invariant[%0d]: got ctl=%b%b%b%b with valid=0 required 0000",
                         i, got.wreg, got.m2reg, got.wmem, got.jal);
            end
        end
    endtask

    task automatic test_async_reset();
        din_t d;
        d = rand_din();
        d.valid = 1'b1; d.wreg = 1'b1;
        drive_cycle(d, 1'b0, 1'b0, 1'b0);
        void'(sb.pop_front());
        stall = 1'b1;
        flush = 1'b1;
        #2;
        resetn = 1'b0;
        #1;
        got = observe();
        n_checks++;
        if (got !== st_t'('0)) begin
            n_fail++;
            $display("FAIL async_reset_now: got=%h required=0", got);
        end
        @(posedge clock);
        #1;
        got = observe();
        n_checks++;
        if (got !== st_t'('0)) begin
            n_fail++;
            $display("FAIL async_reset_hold: got=%h required=0", got);
        end
        model = '0;
        sb.delete();
        @(negedge clock);
        resetn = 1'b1;
        d = rand_din();
        d.valid = 1'b1;
        drive_cycle(d, 1'b0, 1'b0, 1'b0);
        exp_s = sb.pop_front();
        got = observe();
        n_checks++;
        if (got !== exp_s || got.valid !== 1'b1 || got.a !== d.a) begin
            n_fail++;
            $display("FAIL async_resume: got=%h required=%h", got, exp_s);
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_stall();
        test_flush_over_stall();
        test_invalid_load();
        test_saturation();
        test_back_to_back();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
